// File: rtl/serial_word_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_packer_pkg : shared types/constants for serial_word_packer      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package word_packer_pkg;

  localparam int DROP_COUNT_W = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

endpackage : word_packer_pkg
`default_nettype wire

// File: rtl/serial_word_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_word_packer_if : serial bit input + packed-word output port   |
// | drop_count exists only with SERIAL_WORD_PACKER_DROP_COUNT_EN         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface serial_word_packer_if
  import word_packer_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
`ifdef SERIAL_WORD_PACKER_DROP_COUNT_EN
  logic [DROP_COUNT_W-1:0] drop_count;

  modport master (
    input  bit_in, bit_valid, clear, out_ready,
    output out_data, out_valid, overflow, drop_count
  );

  modport slave (
    output bit_in, bit_valid, clear, out_ready,
    input  out_data, out_valid, overflow, drop_count
  );
`else
  modport master (
    input  bit_in, bit_valid, clear, out_ready,
    output out_data, out_valid, overflow
  );

  modport slave (
    output bit_in, bit_valid, clear, out_ready,
    input  out_data, out_valid, overflow
  );
`endif

endinterface : serial_word_packer_if
`default_nettype wire

// File: rtl/serial_word_packer_bit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_counter : modulo-MODULUS counter, enable, sync clear, term count |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bit_counter #(
  parameter int MODULUS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int c_cnt_w = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MODULUS - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= tc ? '0 : r_count + c_cnt_w'(1);
    end
  end

  assign tc = (r_count == c_last);

endmodule : bit_counter
`default_nettype wire

// File: rtl/serial_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_word_packer : packs serial bits MSB-first into WIDTH-bit words|
// | behind one holding register. Option: SERIAL_WORD_PACKER_DROP_COUNT_EN|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_word_packer
  import word_packer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_packer_if.master bus
);

  logic             w_tc;
  logic             w_accept;
  logic             w_complete;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;
  // Only WIDTH-1 bits need storing; the newest bit joins straight from bit_in.
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_overflow;
  hold_state_e      r_state;
  hold_state_e      w_state_nxt;

  assign w_accept   = bus.bit_valid & ~bus.clear;
  assign w_complete = w_accept & w_tc;
  assign w_word     = {r_shift, bus.bit_in};

  bit_counter #(
    .MODULUS (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .en  (w_accept),
    .clr (bus.clear),
    .tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= w_word[WIDTH-2:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_complete) begin
          w_load      = 1'b1;
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          if (w_complete) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = EMPTY;
          end
        end else if (w_complete) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_load) begin
      r_hold <= w_word;
    end
  end

  // A drop can never coincide with clear, since clear blocks completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef SERIAL_WORD_PACKER_DROP_COUNT_EN
  logic [DROP_COUNT_W-1:0] r_drop_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_count <= '0;
    end else if (bus.clear) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != {DROP_COUNT_W{1'b1}})) begin
      r_drop_count <= r_drop_count + DROP_COUNT_W'(1);
    end
  end

  assign bus.drop_count = r_drop_count;
`endif

  assign bus.out_data  = r_hold;
  assign bus.out_valid = (r_state == FULL);
  assign bus.overflow  = r_overflow;

endmodule : serial_word_packer
`default_nettype wire

// File: tb/tb_serial_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_word_packer : directed table + sequence bench, WIDTH=8     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_serial_word_packer;
  import word_packer_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic             bv;
    logic             bi;
    logic             clr;
    logic             rdy;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic             eo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  serial_word_packer_if #(.WIDTH(WIDTH)) bus ();

  serial_word_packer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic bv, input logic bi, input logic clr, input logic rdy);
    bus.bit_valid = bv;
    bus.bit_in    = bi;
    bus.clear     = clr;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [WIDTH-1:0] ed,
                         input logic eo);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".data"},  32'(bus.out_data),  32'(ed));
    chk({tag, ".ovf"},   32'(bus.overflow),  32'(eo));
  endtask

  function automatic void add(input logic bv, input logic bi, input logic clr, input logic rdy,
                              input logic ev, input logic [WIDTH-1:0] ed, input logic eo);
    vq.push_back('{bv, bi, clr, rdy, ev, ed, eo});
  endfunction

  // Feeds one full word MSB-first with out_ready held at rdy; no checks.
  task automatic feed_word(input logic [WIDTH-1:0] w, input logic rdy);
    for (int i = WIDTH - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, rdy);
  endtask

  initial begin
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic [15:0]      two;
    wa = 8'hB2;
    wb = 8'h5C;
    two = {wa, wb};
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, '0, 1'b0);
`ifdef SERIAL_WORD_PACKER_DROP_COUNT_EN
    chk("reset.drop_count", 32'(bus.drop_count), 32'd0);
`endif
    rst = 1'b1;

    // Single word B2, ready high: valid for exactly one cycle.
    for (int i = 0; i < 8; i++)
      add(1'b1, wa[7-i], 1'b0, 1'b1, (i == 7), (i == 7) ? wa : 8'h00, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, wa, 1'b0);
    // Continuous 16 bits: B2 then 5C.
    for (int i = 0; i < 16; i++)
      add(1'b1, two[15-i], 1'b0, 1'b1, (i == 7) || (i == 15), (i < 15) ? wa : wb, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, wb, 1'b0);
    // bit_valid on every third cycle.
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, wb, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, wb, 1'b0);
      add(1'b1, wa[7-i], 1'b0, 1'b1, (i == 7), (i == 7) ? wa : wb, 1'b0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, wa, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].bv, vq[i].bi, vq[i].clr, vq[i].rdy);
      chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].eo);
    end

    // Overflow: second word dropped while first is held.
    feed_word(wb, 1'b0);
    chk_out("ovf.first", 1'b1, wb, 1'b0);
    feed_word(wa, 1'b0);
    chk_out("ovf.drop", 1'b1, wb, 1'b1);
`ifdef SERIAL_WORD_PACKER_DROP_COUNT_EN
    chk("ovf.drop_count", 32'(bus.drop_count), 32'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("ovf.xfer", 1'b0, wb, 1'b1);

    // Clear discards a 3-bit partial word and the bit presented with it.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk_out("clr.pulse", 1'b0, wb, 1'b0);
`ifdef SERIAL_WORD_PACKER_DROP_COUNT_EN
    chk("clr.drop_count", 32'(bus.drop_count), 32'd0);
`endif
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr.early_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk_out("clr.word", 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr.xfer", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with a word held, overflow set and 5 bits pending.
    feed_word(wa, 1'b0);
    feed_word(wb, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("rst.pre", 1'b1, wa, 1'b1);
    bus.bit_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, wb[7-i], 1'b0, 1'b1);
      chk($sformatf("rst.bit%0d", i), 32'(bus.out_valid), 32'd0);
    end
    step(1'b1, wb[0], 1'b0, 1'b1);
    chk_out("rst.word", 1'b1, wb, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_serial_word_packer
`default_nettype wire
